// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and the EX/MEM memory-controller state encoding.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_WAIT   = 2'd1,
        MEM_HALTED = 2'd2
    } memstate_t;

endpackage

// File: rtl/ex_mem_if.sv
// Signal bundle between the ID/EX latch, the EX/MEM stage and the dcache.
interface ex_mem_if;
    import cpu_types_pkg::*;

    logic     exW;
    logic     exRST;
    logic     excuDRE;
    logic     excuDWE;
    logic     excuHALT;
    logic     exdatomic;
    logic     exMemToReg;
    logic     exWEN;
    logic     exJALflag;
    word_t    exaluout;
    word_t    exrdat2;
    regbits_t exwsel;
    word_t    exiaddr;
    logic     dhit;

    logic     memMemToReg;
    logic     memWEN;
    logic     memJALflag;
    word_t    memaluout;
    word_t    memiaddr;
    regbits_t memwsel;
    logic     dREN;
    logic     dWEN;
    logic     datomic;
    word_t    daddr;
    word_t    dstore;
    logic     mem_stall;
    logic     halt;

    modport exmem (
        input  exW, exRST, excuDRE, excuDWE, excuHALT, exdatomic,
               exMemToReg, exWEN, exJALflag, exaluout, exrdat2, exwsel,
               exiaddr, dhit,
        output memMemToReg, memWEN, memJALflag, memaluout, memiaddr, memwsel,
               dREN, dWEN, datomic, daddr, dstore, mem_stall, halt
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter for performance statistics.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count qualified cycles, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with dcache request control, sticky halt and
// a saturating memory-stall cycle counter.
module ex_mem_stage
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             exW,
    input  logic             exRST,
    input  logic             excuDRE,
    input  logic             excuDWE,
    input  logic             excuHALT,
    input  logic             exdatomic,
    input  logic             exMemToReg,
    input  logic             exWEN,
    input  logic             exJALflag,
    input  word_t            exaluout,
    input  word_t            exrdat2,
    input  regbits_t         exwsel,
    input  word_t            exiaddr,
    input  logic             dhit,
    output logic             memMemToReg,
    output logic             memWEN,
    output logic             memJALflag,
    output word_t            memaluout,
    output word_t            memiaddr,
    output regbits_t         memwsel,
    output logic             dREN,
    output logic             dWEN,
    output logic             datomic,
    output word_t            daddr,
    output word_t            dstore,
    output logic             mem_stall,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    memstate_t state;
    logic      lat_dre;
    logic      lat_dwe;
    logic      lat_atomic;
    logic      cap;
    logic      load_op;

    // A flushed capture is a bubble, so it can never start an access or halt.
    always_comb begin
        halt      = (state == MEM_HALTED);
        mem_stall = (state == MEM_WAIT) && !dhit;
        cap       = exW && !mem_stall && !halt;
        load_op   = cap && !exRST;
        dREN      = (state == MEM_WAIT) && lat_dre;
        dWEN      = (state == MEM_WAIT) && lat_dwe;
        datomic   = (state == MEM_WAIT) && lat_atomic;
        daddr     = memaluout;
    end

    // Pipeline register: load EX values or a bubble on capture, else hold.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            memMemToReg <= 1'b0;
            memWEN      <= 1'b0;
            memJALflag  <= 1'b0;
            memaluout   <= '0;
            memiaddr    <= '0;
            memwsel     <= '0;
            dstore      <= '0;
            lat_dre     <= 1'b0;
            lat_dwe     <= 1'b0;
            lat_atomic  <= 1'b0;
        end else if (cap) begin
            memMemToReg <= exRST ? 1'b0 : exMemToReg;
            memWEN      <= exRST ? 1'b0 : exWEN;
            memJALflag  <= exRST ? 1'b0 : exJALflag;
            memaluout   <= exRST ? '0 : exaluout;
            memiaddr    <= exRST ? '0 : exiaddr;
            memwsel     <= exRST ? '0 : exwsel;
            dstore      <= exRST ? '0 : exrdat2;
            lat_dre     <= exRST ? 1'b0 : excuDRE;
            lat_dwe     <= exRST ? 1'b0 : excuDWE;
            lat_atomic  <= exRST ? 1'b0 : exdatomic;
        end
    end

    // Request FSM: the next state follows whatever is captured, which covers
    // IDLE->WAIT, WAIT->WAIT back-to-back and WAIT->HALTED on the dhit edge.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= MEM_IDLE;
        end else if (cap) begin
            if (load_op && (excuDRE || excuDWE)) begin
                state <= MEM_WAIT;
            end else if (load_op && excuHALT) begin
                state <= MEM_HALTED;
            end else begin
                state <= MEM_IDLE;
            end
        end else if ((state == MEM_WAIT) && dhit) begin
            state <= MEM_IDLE;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .rst_n (nRST),
        .inc   (mem_stall),
        .count (stall_cnt)
    );

    a_no_rw_capture : assert property (@(posedge CLK) disable iff (!nRST)
        load_op |-> !(excuDRE && excuDWE));

    a_no_dual_request : assert property (@(posedge CLK) disable iff (!nRST)
        !(dREN && dWEN));

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage.
module tb_ex_mem_stage;
    import cpu_types_pkg::*;

    logic       CLK;
    logic       nRST;
    logic [15:0] stall_cnt;
    logic       d2_MemToReg, d2_WEN, d2_JALflag, d2_dREN, d2_dWEN, d2_datomic;
    logic       d2_mem_stall, d2_halt;
    word_t      d2_aluout, d2_iaddr, d2_daddr, d2_dstore;
    regbits_t   d2_wsel;
    logic [1:0] d2_stall_cnt;

    int total = 0;
    int bad   = 0;

    ex_mem_if exif ();

    ex_mem_stage #(.CNT_W(16)) dut (
        .CLK(CLK), .nRST(nRST), .exW(exif.exW), .exRST(exif.exRST),
        .excuDRE(exif.excuDRE), .excuDWE(exif.excuDWE), .excuHALT(exif.excuHALT),
        .exdatomic(exif.exdatomic), .exMemToReg(exif.exMemToReg), .exWEN(exif.exWEN),
        .exJALflag(exif.exJALflag), .exaluout(exif.exaluout), .exrdat2(exif.exrdat2),
        .exwsel(exif.exwsel), .exiaddr(exif.exiaddr), .dhit(exif.dhit),
        .memMemToReg(exif.memMemToReg), .memWEN(exif.memWEN), .memJALflag(exif.memJALflag),
        .memaluout(exif.memaluout), .memiaddr(exif.memiaddr), .memwsel(exif.memwsel),
        .dREN(exif.dREN), .dWEN(exif.dWEN), .datomic(exif.datomic), .daddr(exif.daddr),
        .dstore(exif.dstore), .mem_stall(exif.mem_stall), .halt(exif.halt),
        .stall_cnt(stall_cnt)
    );

    ex_mem_stage #(.CNT_W(2)) dut2 (
        .CLK(CLK), .nRST(nRST), .exW(exif.exW), .exRST(exif.exRST),
        .excuDRE(exif.excuDRE), .excuDWE(exif.excuDWE), .excuHALT(exif.excuHALT),
        .exdatomic(exif.exdatomic), .exMemToReg(exif.exMemToReg), .exWEN(exif.exWEN),
        .exJALflag(exif.exJALflag), .exaluout(exif.exaluout), .exrdat2(exif.exrdat2),
        .exwsel(exif.exwsel), .exiaddr(exif.exiaddr), .dhit(exif.dhit),
        .memMemToReg(d2_MemToReg), .memWEN(d2_WEN), .memJALflag(d2_JALflag),
        .memaluout(d2_aluout), .memiaddr(d2_iaddr), .memwsel(d2_wsel),
        .dREN(d2_dREN), .dWEN(d2_dWEN), .datomic(d2_datomic), .daddr(d2_daddr),
        .dstore(d2_dstore), .mem_stall(d2_mem_stall), .halt(d2_halt),
        .stall_cnt(d2_stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ex(input logic dre, input logic dwe, input logic hlt,
                          input logic at, input logic mtr, input logic wen,
                          input logic jal, input word_t alu, input word_t rd,
                          input regbits_t ws, input word_t ia);
        exif.excuDRE    = dre;
        exif.excuDWE    = dwe;
        exif.excuHALT   = hlt;
        exif.exdatomic  = at;
        exif.exMemToReg = mtr;
        exif.exWEN      = wen;
        exif.exJALflag  = jal;
        exif.exaluout   = alu;
        exif.exrdat2    = rd;
        exif.exwsel     = ws;
        exif.exiaddr    = ia;
    endtask

    task automatic do_reset;
        nRST       = 1'b0;
        exif.exW   = 1'b0;
        exif.exRST = 1'b0;
        exif.dhit  = 1'b0;
        set_ex(0, 0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_reset;
        nRST       = 1'b0;
        exif.exW   = 1'b0;
        exif.exRST = 1'b0;
        exif.dhit  = 1'b0;
        set_ex(0, 0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
        #2;
        total++;
        if ({exif.memMemToReg, exif.memWEN, exif.memJALflag, exif.dREN, exif.dWEN,
             exif.datomic, exif.mem_stall, exif.halt} !== 8'h00 ||
            exif.memaluout !== 32'h0 || exif.memiaddr !== 32'h0 || exif.dstore !== 32'h0 ||
            exif.memwsel !== 5'd0 || stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_state: ctl=%b alu=%h cnt=%0d want all zero",
                     {exif.memWEN, exif.dREN, exif.mem_stall, exif.halt}, exif.memaluout, stall_cnt);
        end
        tick();
        nRST = 1'b1;
        // load in flight, then reset mid-WAIT
        set_ex(1, 0, 0, 0, 1, 1, 0, 32'h44, 32'h0, 5'd6, 32'h8);
        exif.exW = 1'b1;
        tick();
        tick();
        total++;
        if ({exif.dREN, exif.mem_stall, exif.memWEN} !== 3'b111 || stall_cnt !== 16'd1) begin
            bad++;
            $display("FAIL reset_pre_wait: dREN/stall/wen=%b cnt=%0d want 111 cnt=1",
                     {exif.dREN, exif.mem_stall, exif.memWEN}, stall_cnt);
        end
        #2;
        nRST = 1'b0;
        #1;
        total++;
        if ({exif.dREN, exif.mem_stall, exif.memWEN, exif.memMemToReg} !== 4'b0000 ||
            exif.daddr !== 32'h0 || exif.memwsel !== 5'd0 || stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_mid_wait: ctl=%b daddr=%h cnt=%0d want 0000 0 0",
                     {exif.dREN, exif.mem_stall, exif.memWEN, exif.memMemToReg}, exif.daddr, stall_cnt);
        end
        exif.exW = 1'b0;
        tick();
        nRST = 1'b1;
        #1;
        total++;
        if ({exif.dREN, exif.mem_stall} !== 2'b00) begin
            bad++;
            $display("FAIL reset_idle_after: dREN/stall=%b want 00", {exif.dREN, exif.mem_stall});
        end
    endtask

    task automatic test_load;
        do_reset();
        set_ex(1, 0, 0, 0, 1, 1, 0, 32'h40, 32'h0, 5'd3, 32'h10);
        exif.exW = 1'b1;
        tick();
        set_ex(0, 0, 0, 0, 0, 1, 0, 32'h1234, 32'h0, 5'd5, 32'h14);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({exif.dREN, exif.dWEN, exif.mem_stall} !== 3'b101 || exif.daddr !== 32'h40 ||
                exif.memwsel !== 5'd3) begin
                bad++;
                $display("FAIL load_stall%0d: req/stall=%b daddr=%h want 101 00000040",
                         i, {exif.dREN, exif.dWEN, exif.mem_stall}, exif.daddr);
            end
            tick();
        end
        exif.dhit = 1'b1;
        #1;
        total++;
        if ({exif.dREN, exif.mem_stall} !== 2'b10) begin
            bad++;
            $display("FAIL load_hit: dREN/stall=%b want 10", {exif.dREN, exif.mem_stall});
        end
        tick();
        exif.dhit = 1'b0;
        #1;
        total++;
        if (exif.memaluout !== 32'h1234 || exif.memwsel !== 5'd5 || exif.memMemToReg !== 1'b0 ||
            exif.dREN !== 1'b0 || stall_cnt !== 16'd3) begin
            bad++;
            $display("FAIL load_next_capture: alu=%h ws=%0d dREN=%b cnt=%0d want 00001234 5 0 3",
                     exif.memaluout, exif.memwsel, exif.dREN, stall_cnt);
        end
    endtask

    task automatic test_sc;
        do_reset();
        set_ex(0, 1, 0, 1, 0, 0, 0, 32'h80, 32'hDEADBEEF, 5'd0, 32'h20);
        exif.exW = 1'b1;
        tick();
        set_ex(0, 0, 0, 0, 0, 0, 0, '0, '0, '0, 32'h24);
        exif.dhit = 1'b1;
        #1;
        total++;
        if ({exif.dREN, exif.dWEN, exif.datomic, exif.mem_stall} !== 4'b0110 ||
            exif.daddr !== 32'h80 || exif.dstore !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL sc_request: ren/wen/at/stall=%b daddr=%h dstore=%h want 0110 00000080 deadbeef",
                     {exif.dREN, exif.dWEN, exif.datomic, exif.mem_stall}, exif.daddr, exif.dstore);
        end
        tick();
        exif.dhit = 1'b0;
        #1;
        total++;
        if ({exif.dWEN, exif.datomic, exif.mem_stall} !== 3'b000 || stall_cnt !== 16'd0 ||
            exif.memiaddr !== 32'h24) begin
            bad++;
            $display("FAIL sc_done: wen/at/stall=%b cnt=%0d ia=%h want 000 0 00000024",
                     {exif.dWEN, exif.datomic, exif.mem_stall}, stall_cnt, exif.memiaddr);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        set_ex(1, 0, 0, 0, 1, 1, 0, 32'h10, 32'h0, 5'd1, 32'h40);
        exif.exW = 1'b1;
        tick();
        set_ex(1, 0, 0, 0, 1, 1, 0, 32'h14, 32'h0, 5'd2, 32'h44);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) exif.dhit = 1'b1;
            #1;
            total++;
            if (exif.dREN !== 1'b1 || exif.daddr !== 32'h10 || exif.mem_stall !== (i != 2)) begin
                bad++;
                $display("FAIL b2b_first%0d: dREN=%b stall=%b daddr=%h want 1 %b 00000010",
                         i, exif.dREN, exif.mem_stall, exif.daddr, i != 2);
            end
            tick();
        end
        exif.dhit = 1'b0;
        set_ex(0, 0, 0, 0, 0, 0, 0, '0, '0, '0, 32'h48);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) exif.dhit = 1'b1;
            #1;
            total++;
            if (exif.dREN !== 1'b1 || exif.daddr !== 32'h14 || exif.memwsel !== 5'd2 ||
                exif.mem_stall !== (i != 2)) begin
                bad++;
                $display("FAIL b2b_second%0d: dREN=%b stall=%b daddr=%h want 1 %b 00000014",
                         i, exif.dREN, exif.mem_stall, exif.daddr, i != 2);
            end
            tick();
        end
        exif.dhit = 1'b0;
        #1;
        total++;
        if (exif.dREN !== 1'b0 || stall_cnt !== 16'd4 || exif.memiaddr !== 32'h48) begin
            bad++;
            $display("FAIL b2b_done: dREN=%b cnt=%0d ia=%h want 0 4 00000048",
                     exif.dREN, stall_cnt, exif.memiaddr);
        end
    endtask

    task automatic test_flush_during_wait;
        do_reset();
        set_ex(1, 0, 0, 0, 1, 1, 0, 32'h20, 32'h0, 5'd7, 32'h60);
        exif.exW = 1'b1;
        tick();
        set_ex(0, 0, 0, 0, 0, 1, 1, 32'h99, 32'h5, 5'd9, 32'h64);
        exif.exRST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if ({exif.dREN, exif.mem_stall, exif.memWEN, exif.memMemToReg} !== 4'b1111 ||
                exif.memwsel !== 5'd7 || exif.daddr !== 32'h20) begin
                bad++;
                $display("FAIL flush_hold%0d: ren/stall/wen/mtr=%b ws=%0d daddr=%h want 1111 7 00000020",
                         i, {exif.dREN, exif.mem_stall, exif.memWEN, exif.memMemToReg},
                         exif.memwsel, exif.daddr);
            end
            tick();
        end
        exif.dhit = 1'b1;
        tick();
        exif.dhit  = 1'b0;
        exif.exRST = 1'b0;
        exif.exW   = 1'b0;
        #1;
        total++;
        if ({exif.memWEN, exif.memJALflag, exif.dREN, exif.mem_stall} !== 4'b0000 ||
            exif.memwsel !== 5'd0 || exif.memaluout !== 32'h0 || exif.memiaddr !== 32'h0) begin
            bad++;
            $display("FAIL flush_bubble: wen/jal/ren/stall=%b ws=%0d alu=%h want 0000 0 0",
                     {exif.memWEN, exif.memJALflag, exif.dREN, exif.mem_stall}, exif.memwsel, exif.memaluout);
        end
        exif.dhit = 1'b1;
        tick();
        exif.dhit = 1'b0;
        #1;
        total++;
        if ({exif.dREN, exif.mem_stall} !== 2'b00 || stall_cnt !== 16'd2) begin
            bad++;
            $display("FAIL idle_dhit_ignored: ren/stall=%b cnt=%0d want 00 2",
                     {exif.dREN, exif.mem_stall}, stall_cnt);
        end
    endtask

    task automatic test_halt;
        do_reset();
        set_ex(0, 1, 0, 0, 0, 0, 0, 32'h30, 32'h55, 5'd0, 32'h2C);
        exif.exW = 1'b1;
        tick();
        set_ex(0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h100);
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if ({exif.dWEN, exif.mem_stall, exif.halt} !== 3'b110 || exif.dstore !== 32'h55) begin
                bad++;
                $display("FAIL halt_store_wait%0d: wen/stall/halt=%b dstore=%h want 110 00000055",
                         i, {exif.dWEN, exif.mem_stall, exif.halt}, exif.dstore);
            end
            tick();
        end
        exif.dhit = 1'b1;
        #1;
        total++;
        if ({exif.dWEN, exif.mem_stall, exif.halt} !== 3'b100) begin
            bad++;
            $display("FAIL halt_hit_cycle: wen/stall/halt=%b want 100", {exif.dWEN, exif.mem_stall, exif.halt});
        end
        tick();
        exif.dhit = 1'b0;
        #1;
        total++;
        if ({exif.halt, d2_halt, exif.dWEN} !== 3'b110 || exif.memiaddr !== 32'h100) begin
            bad++;
            $display("FAIL halt_rise: halt/halt2/wen=%b ia=%h want 110 00000100",
                     {exif.halt, d2_halt, exif.dWEN}, exif.memiaddr);
        end
        set_ex(1, 0, 0, 1, 1, 1, 1, 32'hABC, 32'h77, 5'd2, 32'h200);
        for (int i = 0; i < 3; i++) begin
            exif.exRST = i[0];
            exif.dhit  = i[0];
            tick();
            #1;
            total++;
            if ({exif.halt, exif.dREN, exif.dWEN, exif.mem_stall, exif.memWEN} !== 5'b10000 ||
                exif.memiaddr !== 32'h100 || exif.memaluout !== 32'h0) begin
                bad++;
                $display("FAIL halt_frozen%0d: halt/ren/wen/stall/wenr=%b ia=%h want 10000 00000100",
                         i, {exif.halt, exif.dREN, exif.dWEN, exif.mem_stall, exif.memWEN}, exif.memiaddr);
            end
        end
        total++;
        if (stall_cnt !== 16'd5 || d2_stall_cnt !== 2'd3) begin
            bad++;
            $display("FAIL halt_stall_cnt: cnt16=%0d cnt2=%0d want 5 3", stall_cnt, d2_stall_cnt);
        end
        exif.exW   = 1'b0;
        exif.exRST = 1'b0;
        exif.dhit  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_sc();
        test_back_to_back();
        test_flush_during_wait();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
